// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial subtractor: computes Diff = A - B - Bin over WIDTH clock cycles
// using a single full-subtractor cell and a registered borrow.
//
// Handshake: start is honoured only in IDLE. The edge that sees IDLE with
// start=1 captures A, B and Bin. busy stays high through RUN and DONE. done
// pulses for exactly one cycle, and Diff/Bout are valid during that cycle.
// start has no effect in RUN or DONE, and nothing is queued.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      launch request (sampled in IDLE only)
//   A, B       unsigned minuend / subtrahend, WIDTH bits
//   Bin        initial borrow-in
//   busy       high in RUN and DONE
//   done       one-cycle result-valid pulse
//   Diff       registered difference, held between operations
//   Bout       registered final borrow-out, held between operations
//   fsm_state  current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic [1:0]       fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a_i, b_i, d_bit, br_next, last_bit;

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        a_i      = a_sr[0];
        b_i      = b_sr[0];
        d_bit    = a_i ^ b_i ^ br;
        br_next  = (~(a_i ^ b_i) & br) | (~a_i & b_i);
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath: operand shift registers, result assembly, borrow and counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            Diff   <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        br     <= Bin;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    // Each new difference bit enters at the MSB, so after
                    // WIDTH shifts bit 0 has arrived at the LSB.
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        // The register has not taken the final shift yet,
                        // so publish the shifted value directly.
                        Diff <= {d_bit, res_sr[WIDTH-1:1]};
                        Bout <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // These outputs decode the state register directly. No input feeds them.
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        fsm_state = state_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  // WIDTH=8 instance
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic [1:0] st8;

  // WIDTH=4 instance for the exhaustive sweep
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic [1:0] st4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [8:0] exp_q8[$];
  logic [4:0] exp_q4[$];
  logic       prev_done8 = 1'b0;
  logic       prev_done4 = 1'b0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8), .fsm_state(st8)
  );

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Bin(bin4),
    .busy(busy4), .done(done4), .Diff(diff4), .Bout(bout4), .fsm_state(st4)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && done8) begin
      check("done8_not_consecutive", {31'd0, prev_done8}, 32'd0);
      if (exp_q8.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done8_unexpected: got done with no pending result, diff=%0h bout=%0b", diff8, bout8);
      end else begin
        logic [8:0] e;
        e = exp_q8.pop_front();
        check("result8 {bout,diff}", {23'd0, bout8, diff8}, {23'd0, e});
      end
    end
    prev_done8 = rst_n && done8;
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (prev_done4) begin
        n_cmp++;
        n_err++;
        $display("FAIL done4_consecutive: got two done cycles, required one");
      end
      if (exp_q4.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done4_unexpected: got done with no pending result, diff=%0h bout=%0b", diff4, bout4);
      end else begin
        logic [4:0] e;
        e = exp_q4.pop_front();
        check("result4 {bout,diff}", {27'd0, bout4, diff4}, {27'd0, e});
      end
    end
    prev_done4 = rst_n && done4;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle8();
    int t = 0;
    while (busy8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy8) check("wait_idle8_timeout", {31'd0, busy8}, 32'd0);
  endtask

  task automatic wait_idle4();
    int t = 0;
    while (busy4 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy4) check("wait_idle4_timeout", {31'd0, busy4}, 32'd0);
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [8:0] exp, input bit push);
    wait_idle8();
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    if (push) exp_q8.push_back(exp);
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                     input logic [4:0] exp);
    wait_idle4();
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    exp_q4.push_back(exp);
    @(posedge clk);
    #1 start4 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, busy_n;
    int acc[4];
    logic [7:0] bb_a[4], bb_b[4];
    logic       bb_bin[4];
    logic [8:0] bb_exp[4];

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;

    // Reset state
    #1;
    check("reset_diff8", {24'd0, diff8}, 32'd0);
    check("reset_bout8", {31'd0, bout8}, 32'd0);
    check("reset_busy8", {31'd0, busy8}, 32'd0);
    check("reset_done8", {31'd0, done8}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 100 - 37 - 0 = 63: latency and busy length
    op8(8'd100, 8'd37, 1'b0, {1'b0, 8'd63}, 1'b1);
    n = 0;
    busy_n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (busy8) busy_n++;
      if (done8) break;
    end
    check("done_latency", n, 32'd9);
    check("busy_cycles", busy_n, 32'd9);
    @(negedge clk);
    check("busy_low_after_done", {31'd0, busy8}, 32'd0);

    op8(8'd5, 8'd9, 1'b0, {1'b1, 8'hFC}, 1'b1);
    op8(8'd0, 8'd0, 1'b1, {1'b1, 8'hFF}, 1'b1);
    wait_idle8();

    // start pulses and operand changes during RUN are ignored
    op8(8'd77, 8'd7, 1'b1, {1'b0, 8'd69}, 1'b1);
    @(negedge clk);                       // RUN cycle 1
    @(negedge clk);                       // RUN cycle 2
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2; bin8 = 1'b0;
    @(negedge clk);                       // RUN cycle 3
    start8 = 1'b0;
    check("diff_held_in_run", {24'd0, diff8}, 32'hFF);
    check("bout_held_in_run", {31'd0, bout8}, 32'd1);
    @(negedge clk);                       // RUN cycle 4
    @(negedge clk);                       // RUN cycle 5
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
    repeat (12) @(negedge clk);
    check("no_relaunch_busy", {31'd0, busy8}, 32'd0);

    op8(8'hFF, 8'hFF, 1'b0, {1'b0, 8'h00}, 1'b1);
    wait_idle8();

    // Back-to-back with start held high
    bb_a   = '{8'd200, 8'd16, 8'd3,   8'd128};
    bb_b   = '{8'd100, 8'd1,  8'd4,   8'd127};
    bb_bin = '{1'b0,   1'b1,  1'b1,   1'b0};
    bb_exp = '{{1'b0, 8'h64}, {1'b0, 8'h0E}, {1'b1, 8'hFE}, {1'b0, 8'h01}};
    @(negedge clk);
    start8 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      while (busy8 && t < 50) begin
        @(negedge clk);
        t++;
      end
      a8 = bb_a[k]; b8 = bb_b[k]; bin8 = bb_bin[k];
      exp_q8.push_back(bb_exp[k]);
      acc[k] = cyc + 1;
      @(negedge clk);
      check("b2b_accepted", {31'd0, busy8}, 32'd1);
    end
    start8 = 1'b0;
    for (int k = 1; k < 4; k++) check("b2b_spacing", acc[k] - acc[k-1], 32'd10);
    wait_idle8();
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN
    op8(8'd200, 8'd50, 1'b0, 9'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_diff", {24'd0, diff8}, 32'd0);
    check("midrun_reset_bout", {31'd0, bout8}, 32'd0);
    check("midrun_reset_busy", {31'd0, busy8}, 32'd0);
    check("midrun_reset_done", {31'd0, done8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_idle", {31'd0, busy8}, 32'd0);
    op8(8'd50, 8'd20, 1'b1, {1'b0, 8'd29}, 1'b1);
    wait_idle8();

    // WIDTH=4 exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [4:0] e;
          e[3:0] = 4'((a - b - c) & 15);
          e[4]   = (a < b + c);
          op4(4'(a), 4'(b), c[0], e);
        end
      end
    end

    // Drain scoreboards
    n = 0;
    while ((exp_q8.size() != 0 || exp_q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_q8", exp_q8.size(), 32'd0);
    check("drain_q4", exp_q4.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
